// File: rtl/dmem_controller_pkg.sv
// Shared types and constants for the wait-state data-memory controller.
// Request payload, FSM states and MMIO register offsets.
package dmem_controller_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LANES   = WORD_W / 8;
  localparam int unsigned WAIT_W  = 4;

  localparam logic [WORD_W-1:0] CONSOLE_OFFSET = 32'h0000_0000;
  localparam logic [WORD_W-1:0] CYCLE_OFFSET   = 32'h0000_0004;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmemState_;

  typedef struct packed {
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] storeData;
    logic [LANES-1:0]  byteEnable;
    logic              isStore;
    logic              isLoad;
  } dmemRequest_;

  // Merge the enabled byte lanes of newData over oldData.
  function automatic logic [WORD_W-1:0] mergeLanes(input logic [WORD_W-1:0] oldData,
                                                   input logic [WORD_W-1:0] newData,
                                                   input logic [LANES-1:0]  lanes);
    logic [WORD_W-1:0] merged;
    merged = oldData;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lanes[i]) merged[8*i +: 8] = newData[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Word-organised backing RAM: synchronous byte-lane write, combinational read.
module dmem_ram_array
  import dmem_controller_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clock,
  input  logic                           writeEnable,
  input  logic [$clog2(DEPTH_WORDS)-1:0] index,
  input  logic [WORD_W-1:0]              writeData,
  input  logic [LANES-1:0]               byteEnable,
  output logic [WORD_W-1:0]              readData
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (writeEnable) begin
      mem[index] <= mergeLanes(mem[index], writeData, byteEnable);
    end
  end

  assign readData = mem[index];

endmodule

// File: rtl/dmem_controller.sv
// Wait-state data-memory controller: one request at a time, fixed latency,
// RAM plus a small MMIO window (console byte port, free-running cycle counter).
module dmem_controller
  import dmem_controller_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [WORD_W-1:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] storeData,
  input  logic [LANES-1:0]  byteEnable,
  input  logic              storeValid,
  input  logic              loadValid,
  output logic [WORD_W-1:0] loadData,
  output logic              loadDataValid,
  output logic              storeComplete,
  output logic              accessFault,
  output logic              busy,
  output logic [7:0]        consoleData,
  output logic              consoleValid
);

  localparam int unsigned       IDX_W        = $clog2(DEPTH_WORDS);
  localparam logic [WORD_W-1:0] RAM_LIMIT    = WORD_W'(4 * DEPTH_WORDS);
  localparam logic [WORD_W-1:0] CONSOLE_ADDR = MMIO_BASE + CONSOLE_OFFSET;
  localparam logic [WORD_W-1:0] CYCLE_ADDR   = MMIO_BASE + CYCLE_OFFSET;
  localparam logic [WAIT_W-1:0] WAIT_INIT    =
    WAIT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  dmemState_         state, stateNext;
  logic [WAIT_W-1:0] waitCount, waitNext;
  dmemRequest_       request, requestNext;
  logic [WORD_W-1:0] cycleCount;

  logic              ramWrite;
  logic [WORD_W-1:0] ramReadData;
  logic              respLoad, respStore, respFault, consoleWrite;
  logic [WORD_W-1:0] respData;
  logic              isRam, isConsole, isCycle, isConflict;

  // Byte offset within a word is irrelevant; lane steering lives upstream.
  logic unusedAddressBits;
  assign unusedAddressBits = ^address[1:0];

  // Decode of the latched (word-aligned) request address.
  assign isRam      = request.address < RAM_LIMIT;
  assign isConsole  = request.address == CONSOLE_ADDR;
  assign isCycle    = request.address == CYCLE_ADDR;
  assign isConflict = request.isStore & request.isLoad;

  dmem_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clock      (clock),
    .writeEnable(ramWrite & reset),
    .index      (request.address[IDX_W+1:2]),
    .writeData  (request.storeData),
    .byteEnable (request.byteEnable),
    .readData   (ramReadData)
  );

  // State, wait counter, latched request and cycle counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= DMEM_IDLE;
      waitCount  <= '0;
      request    <= '0;
      cycleCount <= '0;
    end else begin
      state      <= stateNext;
      waitCount  <= waitNext;
      request    <= requestNext;
      cycleCount <= cycleCount + 32'd1;
    end
  end

  // Next-state logic and response decode.
  always_comb begin
    stateNext    = state;
    waitNext     = waitCount;
    requestNext  = request;
    ramWrite     = 1'b0;
    respLoad     = 1'b0;
    respStore    = 1'b0;
    respFault    = 1'b0;
    respData     = '0;
    consoleWrite = 1'b0;

    case (state)
      DMEM_IDLE: begin
        if (loadValid || storeValid) begin
          requestNext.address    = {address[WORD_W-1:2], 2'b00};
          requestNext.storeData  = storeData;
          requestNext.byteEnable = byteEnable;
          requestNext.isStore    = storeValid;
          requestNext.isLoad     = loadValid;
          waitNext               = WAIT_INIT;
          stateNext              = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
        end
      end

      DMEM_WAIT: begin
        if (waitCount == '0) begin
          stateNext = DMEM_RESP;
        end else begin
          waitNext = waitCount - WAIT_W'(1);
        end
      end

      DMEM_RESP: begin
        stateNext = DMEM_IDLE;
        if (isConflict) begin
          // Ambiguous request: answer as a faulting store, touch nothing.
          respStore = 1'b1;
          respFault = 1'b1;
        end else if (request.isStore) begin
          respStore = 1'b1;
          if (isRam) begin
            ramWrite = 1'b1;
          end else if (isConsole) begin
            consoleWrite = request.byteEnable[0];
          end else if (!isCycle) begin
            respFault = 1'b1;
          end
        end else begin
          respLoad = 1'b1;
          if (isRam) begin
            respData = ramReadData;
          end else if (isCycle) begin
            respData = cycleCount;
          end else if (!isConsole) begin
            respFault = 1'b1;
          end
        end
      end

      default: stateNext = DMEM_IDLE;
    endcase
  end

  // Registered response outputs; pulses last exactly one cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      loadData      <= '0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
      accessFault   <= 1'b0;
      busy          <= 1'b0;
      consoleData   <= '0;
      consoleValid  <= 1'b0;
    end else begin
      loadData      <= respData;
      loadDataValid <= respLoad;
      storeComplete <= respStore;
      accessFault   <= respFault;
      busy          <= (state != DMEM_IDLE);
      consoleValid  <= consoleWrite;
      if (consoleWrite) consoleData <= request.storeData[7:0];
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Directed self-checking bench for dmem_controller (WAIT_CYCLES=2, DEPTH_WORDS=1024).
module tb_dmem_controller;

  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [3:0]  byteEnable;
  logic        storeValid;
  logic        loadValid;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        accessFault;
  logic        busy;
  logic [7:0]  consoleData;
  logic        consoleValid;

  int compared   = 0;
  int mismatched = 0;
  int unsigned edgeCount = 0;

  dmem_controller #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(2),
    .MMIO_BASE  (MMIO_BASE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .storeData    (storeData),
    .byteEnable   (byteEnable),
    .storeValid   (storeValid),
    .loadValid    (loadValid),
    .loadData     (loadData),
    .loadDataValid(loadDataValid),
    .storeComplete(storeComplete),
    .accessFault  (accessFault),
    .busy         (busy),
    .consoleData  (consoleData),
    .consoleValid (consoleValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edgeCount <= edgeCount + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one request and hold it until a completion pulse or 12 cycles.
  // lat = cycles from the accept edge to the sampled pulse (-1 on timeout).
  // flags = {loadDataValid, storeComplete, accessFault, consoleValid}.
  task automatic access(input logic st, input logic ld, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output int lat, output logic [31:0] rdata,
                        output logic [3:0] flags, output int unsigned respEdge);
    storeValid = st;
    loadValid  = ld;
    address    = addr;
    storeData  = data;
    byteEnable = be;
    lat        = -1;
    rdata      = '0;
    flags      = '0;
    respEdge   = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (loadDataValid || storeComplete) begin
        lat      = k;
        rdata    = loadData;
        flags    = {loadDataValid, storeComplete, accessFault, consoleValid};
        respEdge = edgeCount;
        break;
      end
    end
    storeValid = 1'b0;
    loadValid  = 1'b0;
  endtask

  initial begin : stimulus
    int          lat;
    logic [31:0] rd;
    logic [3:0]  fl;
    int unsigned e1, e2;
    logic [31:0] c1, c2;
    int          pulses;
    logic [5:0]  busyTrace, pulseTrace;
    logic        busySeen;

    reset = 1'b0; storeValid = 1'b0; loadValid = 1'b0;
    address = '0; storeData = '0; byteEnable = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    access(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, lat, rd, fl, e1);
    check("initStore", fl, 4'b0100);

    // Reset held with a pending store: everything stays quiet.
    reset = 1'b0; storeValid = 1'b1; address = 32'h100; storeData = 32'hFFFF_FFFF; byteEnable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("rstHoldCtl", {19'd0, consoleData, loadDataValid, storeComplete, accessFault, busy, consoleValid}, 32'h0);
      check("rstHoldData", loadData, 32'h0);
    end
    storeValid = 1'b0; reset = 1'b1;
    access(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, lat, rd, fl, e1);
    check("rstNoWrite", rd, 32'h0);

    // Store then load, full word.
    access(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'hF, lat, rd, fl, e1);
    check("storeLat", 32'(lat), 32'd3);
    check("storeFlags", fl, 4'b0100);
    access(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, lat, rd, fl, e1);
    check("loadLat", 32'(lat), 32'd3);
    check("loadFlags", fl, 4'b1000);
    check("loadData", rd, 32'hDEAD_BEEF);

    // Partial-lane store, then an all-lanes-off store.
    access(1'b1, 1'b0, 32'h80, 32'h1122_3344, 4'hF, lat, rd, fl, e1);
    access(1'b1, 1'b0, 32'h80, 32'hAABB_CCDD, 4'b0101, lat, rd, fl, e1);
    check("partialFlags", fl, 4'b0100);
    access(1'b0, 1'b1, 32'h82, 32'h0, 4'h0, lat, rd, fl, e1);
    check("partialData", rd, 32'h11BB_33DD);
    access(1'b1, 1'b0, 32'h80, 32'h0000_0000, 4'b0000, lat, rd, fl, e1);
    check("noLaneFlags", fl, 4'b0100);
    access(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, lat, rd, fl, e1);
    check("noLaneData", rd, 32'h11BB_33DD);

    // Load held until its response: one pulse, busy in cycles 1..3.
    access(1'b1, 1'b0, 32'h0, 32'h1357_9BDF, 4'hF, lat, rd, fl, e1);
    loadValid = 1'b1; address = 32'h0;
    pulses = 0; busyTrace = '0; pulseTrace = '0; rd = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      busyTrace[k]  = busy;
      pulseTrace[k] = loadDataValid;
      if (loadDataValid) begin
        pulses++;
        rd        = loadData;
        loadValid = 1'b0;
      end
    end
    loadValid = 1'b0;
    check("heldPulses", 32'(pulses), 32'd1);
    check("heldBusy", {26'd0, busyTrace}, {26'd0, 6'b001110});
    check("heldPulseAt", {26'd0, pulseTrace}, {26'd0, 6'b001000});
    check("heldData", rd, 32'h1357_9BDF);

    // Last RAM word and out-of-range boundaries.
    access(1'b1, 1'b0, 32'hFFC, 32'h5A5A_A5A5, 4'hF, lat, rd, fl, e1);
    access(1'b0, 1'b1, 32'hFFC, 32'h0, 4'h0, lat, rd, fl, e1);
    check("lastWordData", rd, 32'h5A5A_A5A5);
    check("lastWordFlags", fl, 4'b1000);
    access(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, lat, rd, fl, e1);
    check("edgeOorFlags", fl, 4'b1010);
    check("edgeOorData", rd, 32'h0);
    access(1'b0, 1'b1, 32'h2000, 32'h0, 4'h0, lat, rd, fl, e1);
    check("oorLoadFlags", fl, 4'b1010);
    check("oorLoadData", rd, 32'h0);
    check("oorLoadLat", 32'(lat), 32'd3);
    access(1'b1, 1'b0, 32'h2000, 32'hFFFF_FFFF, 4'hF, lat, rd, fl, e1);
    check("oorStoreFlags", fl, 4'b0110);

    // Both valids: faulting store, no write.
    access(1'b1, 1'b1, 32'h40, 32'h0000_0000, 4'hF, lat, rd, fl, e1);
    check("conflictFlags", fl, 4'b0110);
    access(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, lat, rd, fl, e1);
    check("conflictNoWrite", rd, 32'hDEAD_BEEF);

    // Console port.
    access(1'b1, 1'b0, MMIO_BASE, 32'h0000_0041, 4'hF, lat, rd, fl, e1);
    check("consoleFlags", fl, 4'b0101);
    check("consoleData", {24'd0, consoleData}, 32'h41);
    @(posedge clock);
    #1;
    check("consoleOnePulse", {31'd0, consoleValid}, 32'h0);
    access(1'b1, 1'b0, MMIO_BASE, 32'h0000_0099, 4'b1110, lat, rd, fl, e1);
    check("consoleNoLane0", fl, 4'b0100);
    check("consoleKept", {24'd0, consoleData}, 32'h41);
    access(1'b0, 1'b1, MMIO_BASE, 32'h0, 4'h0, lat, rd, fl, e1);
    check("consoleLoadFlags", fl, 4'b1000);
    check("consoleLoadData", rd, 32'h0);
    access(1'b1, 1'b0, MMIO_BASE + 32'h4, 32'h1234_5678, 4'hF, lat, rd, fl, e1);
    check("cycleStoreFlags", fl, 4'b0100);

    // Cycle counter: two reads differ by the elapsed edges.
    access(1'b0, 1'b1, MMIO_BASE + 32'h4, 32'h0, 4'h0, lat, c1, fl, e1);
    check("cycleLoad1Flags", fl, 4'b1000);
    repeat (5) @(posedge clock);
    #1;
    access(1'b0, 1'b1, MMIO_BASE + 32'h4, 32'h0, 4'h0, lat, c2, fl, e2);
    check("cycleDelta", c2 - c1, 32'(e2 - e1));
    check("cycleDeltaAbs", c2 - c1, 32'd9);

    // Reset while the store is waiting: abandoned, no write, FSM back in IDLE.
    storeValid = 1'b1; address = 32'h40; storeData = 32'h7777_7777; byteEnable = 4'hF;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1; storeValid = 1'b0;
    pulses = 0; busySeen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      pulses   += int'(loadDataValid | storeComplete);
      busySeen |= busy;
    end
    check("abortPulses", 32'(pulses), 32'd0);
    check("abortBusy", {31'd0, busySeen}, 32'h0);
    access(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, lat, rd, fl, e1);
    check("abortNoWrite", rd, 32'hDEAD_BEEF);
    check("abortIdleLat", 32'(lat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
